// File: rtl/pc_unit_param.sv
// pc_unit_param: program counter with boot delay, exception entry/return,
// misaligned-target trap and a circular return-address stack.
module pc_unit_param #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VEC = '0,
    parameter logic [W-1:0]   EXC_VEC   = W'(32'h0000_4180),
    parameter int             BOOT_CYC  = 1,
    parameter int             RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_wr,
    input  logic [W-1:0] npc,
    input  logic         exc_req,
    input  logic         eret,
    input  logic         ras_push,
    input  logic         ras_pop,
    output logic [W-1:0] pc,
    output logic         pc_valid,
    output logic [W-1:0] epc,
    output logic         exc_taken,
    output logic         misalign,
    output logic [W-1:0] ras_top,
    output logic         ras_empty,
    output logic         ras_full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = BOOT_CYC > 1 ? $clog2(BOOT_CYC) : 1;

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_boot_cnt;
    logic [W-1:0]   r_pc, r_epc;
    logic           r_exc, r_mis;
    logic [W-1:0]   r_ras [RAS_DEPTH];
    logic [PW-1:0]  r_sp;
    logic [PW:0]    r_cnt;

    logic           w_run, w_boot_done, w_eret, w_wr, w_mis, w_adv, w_trap;
    logic           w_push, w_pop, w_empty, w_full, w_grow;
    logic [PW-1:0]  w_top_idx;
    logic [W-1:0]   w_ret_addr;

    always_ff @(posedge clk) begin
        r_state <= rst ? S_BOOT : w_next;
    end

    always_comb begin
        w_next = (r_state == S_BOOT && w_boot_done) ? S_RUN : r_state;
    end

    always_comb begin
        pc_valid = r_state == S_RUN;
    end

    // One action per edge in RUN: exception beats eret beats pc_wr.
    assign w_run       = r_state == S_RUN;
    assign w_boot_done = r_boot_cnt == CW'(BOOT_CYC - 1);
    assign w_eret      = w_run && !exc_req && eret;
    assign w_wr        = w_run && !exc_req && !eret && pc_wr;
    assign w_mis       = w_wr && (npc[1:0] != 2'b00);
    assign w_adv       = w_wr && !w_mis;
    assign w_trap      = (w_run && exc_req) || w_mis;
    assign w_push      = w_adv && ras_push;
    assign w_pop       = w_adv && ras_pop;
    assign w_empty     = r_cnt == '0;
    assign w_full      = r_cnt == (PW+1)'(RAS_DEPTH);
    assign w_grow      = w_push && (!w_pop || w_empty);
    assign w_top_idx   = r_sp - PW'(1);
    assign w_ret_addr  = r_pc + W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_epc      <= '0;
            r_exc      <= 1'b0;
            r_mis      <= 1'b0;
            r_boot_cnt <= '0;
            r_sp       <= '0;
            r_cnt      <= '0;
        end else begin
            r_exc <= w_trap;
            r_mis <= w_mis;
            if (!w_run)
                r_boot_cnt <= r_boot_cnt + CW'(1);
            if (!w_run && w_boot_done)
                r_pc <= RESET_VEC;
            else if (w_trap) begin
                r_epc <= r_pc;
                r_pc  <= EXC_VEC;
            end else if (w_eret)
                r_pc <= r_epc;
            else if (w_adv)
                r_pc <= npc;
            // A full stack keeps wrapping the pointer, so the oldest slot is overwritten.
            if (w_grow) begin
                r_sp  <= r_sp + PW'(1);
                r_cnt <= w_full ? r_cnt : r_cnt + (PW+1)'(1);
            end else if (w_pop && !w_push && !w_empty) begin
                r_sp  <= w_top_idx;
                r_cnt <= r_cnt - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_grow)
            r_ras[r_sp] <= w_ret_addr;
        else if (!rst && w_push)
            r_ras[w_top_idx] <= w_ret_addr;
    end

    assign pc        = r_pc;
    assign epc       = r_epc;
    assign exc_taken = r_exc;
    assign misalign  = r_mis;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_top   = w_empty ? '0 : r_ras[w_top_idx];
endmodule
